// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared core widths and the W-stage register-file control packet
package core_types_pkg;
  parameter int N_BITS = 32;

  typedef struct packed {
    logic       wen;
    logic [4:0] addr;
  } rf_ctrl_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - W-stage commit, decode read ports and issue/hazard signals of reg_file_sb
interface reg_file_sb_if #(parameter int N_BITS = core_types_pkg::N_BITS);
  core_types_pkg::rf_ctrl_t w_rf_ctrl;
  logic [N_BITS-1:0]        w_data;
  logic                     w_slot;
  logic                     w_vld;
  logic                     rs1_ren;
  logic                     rs2_ren;
  logic [4:0]               rs1_addr;
  logic [4:0]               rs2_addr;
  logic [N_BITS-1:0]        rs1_data;
  logic [N_BITS-1:0]        rs2_data;
  logic                     issue_vld;
  logic                     issue_rd_en;
  logic [4:0]               issue_rd_addr;
  logic                     hazard_stall;
  logic                     pend_any;

  modport master (
    output w_rf_ctrl, w_data, w_slot, w_vld,
    output rs1_ren, rs2_ren, rs1_addr, rs2_addr,
    output issue_vld, issue_rd_en, issue_rd_addr,
    input  rs1_data, rs2_data, hazard_stall, pend_any
  );

  modport slave (
    input  w_rf_ctrl, w_data, w_slot, w_vld,
    input  rs1_ren, rs2_ren, rs1_addr, rs2_addr,
    input  issue_vld, issue_rd_en, issue_rd_addr,
    output rs1_data, rs2_data, hazard_stall, pend_any
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - integer register file with write bypass and per-register in-flight scoreboard
module reg_file_sb #(
  parameter int N_BITS   = core_types_pkg::N_BITS,
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = 2
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [N_BITS-1:0] regs     [1:NUM_REGS-1];
  logic [PEND_W-1:0] pend     [NUM_REGS];
  logic [PEND_W-1:0] pend_nxt [NUM_REGS];
  logic              pend_any_nxt;
  logic [4:0]        waddr;
  logic              commit, dec_en, inc_en, rd_full;

  assign waddr  = bus.w_rf_ctrl.addr;
  assign dec_en = bus.w_slot && bus.w_rf_ctrl.wen && waddr != 5'd0 && 32'(waddr) < NUM_REGS;
  assign commit = dec_en && bus.w_vld;

  function automatic logic [N_BITS-1:0] arr_rd(input logic [4:0] a);
    if (a == 5'd0 || 32'(a) >= NUM_REGS) return '0;
    return regs[a];
  endfunction

  // A retire landing this cycle already releases its count, so a consumer waiting on it proceeds.
  function automatic logic busy(input logic [4:0] a);
    if (a == 5'd0 || 32'(a) >= NUM_REGS) return 1'b0;
    if (dec_en && waddr == a) return pend[a] > PEND_ONE;
    return pend[a] != '0;
  endfunction

  assign bus.rs1_data = (commit && waddr == bus.rs1_addr) ? bus.w_data : arr_rd(bus.rs1_addr);
  assign bus.rs2_data = (commit && waddr == bus.rs2_addr) ? bus.w_data : arr_rd(bus.rs2_addr);

  assign rd_full = bus.issue_rd_en && bus.issue_rd_addr != 5'd0 &&
                   32'(bus.issue_rd_addr) < NUM_REGS && pend[bus.issue_rd_addr] == PEND_MAX;

  assign bus.hazard_stall = (bus.rs1_ren && busy(bus.rs1_addr)) ||
                            (bus.rs2_ren && busy(bus.rs2_addr)) || rd_full;

  assign inc_en = bus.issue_vld && bus.issue_rd_en && bus.issue_rd_addr != 5'd0 &&
                  32'(bus.issue_rd_addr) < NUM_REGS && !bus.hazard_stall;

  always_comb begin
    pend_any_nxt = 1'b0;
    pend_nxt[0]  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      pend_nxt[r] = pend[r];
      if (inc_en && 32'(bus.issue_rd_addr) == r && !(dec_en && 32'(waddr) == r))
        pend_nxt[r] = pend[r] + PEND_ONE;
      else if (dec_en && 32'(waddr) == r && !(inc_en && 32'(bus.issue_rd_addr) == r) &&
               pend[r] != '0)
        pend_nxt[r] = pend[r] - PEND_ONE;
      pend_any_nxt = pend_any_nxt | (pend_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NUM_REGS; r++) regs[r] <= '0;
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
      bus.pend_any <= 1'b0;
    end else begin
      if (commit) regs[waddr] <= bus.w_data;
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= pend_nxt[r];
      bus.pend_any <= pend_any_nxt;
    end
  end

  // Retiring a register with no outstanding writer means the pipeline lost track of it.
  logic [PEND_W-1:0] pend_w;
  assign pend_w = pend[waddr];

  assert property (@(posedge clk) disable iff (!rst_n) dec_en |-> pend_w != '0);
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed and randomized checks of reg_file_sb against a per-register count model
module tb_reg_file_sb;
  localparam int PMAX = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_sb_if bus ();

  reg_file_sb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          exp_acc;
  logic [31:0] obs_rs1, obs_rs2;
  logic        obs_hz, obs_pa;
  int          q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.w_rf_ctrl     = '0;
    bus.w_data        = '0;
    bus.w_slot        = 1'b0;
    bus.w_vld         = 1'b0;
    bus.rs1_ren       = 1'b0;
    bus.rs2_ren       = 1'b0;
    bus.rs1_addr      = '0;
    bus.rs2_addr      = '0;
    bus.issue_vld     = 1'b0;
    bus.issue_rd_en   = 1'b0;
    bus.issue_rd_addr = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic w_set(input bit vld, input int a, input logic [31:0] d);
    bus.w_slot        = 1'b1;
    bus.w_vld         = vld;
    bus.w_rf_ctrl.wen = 1'b1;
    bus.w_rf_ctrl.addr = 5'(a);
    bus.w_data        = d;
  endtask

  task automatic issue(input int a);
    bus.issue_vld     = 1'b1;
    bus.issue_rd_en   = 1'b1;
    bus.issue_rd_addr = 5'(a);
  endtask

  function automatic bit m_busy(input int a, input bit dec, input int wa);
    int c;
    if (a == 0) return 1'b0;
    c = m_cnt[a] - ((dec && wa == a) ? 1 : 0);
    return c > 0;
  endfunction

  function automatic logic [31:0] m_read(input int a, input bit commit, input int wa);
    if (a == 0) return '0;
    if (commit && wa == a) return bus.w_data;
    return m_regs[a];
  endfunction

  // One cycle: inputs already driven; check combinational outputs, clock, check pend_any.
  task automatic step();
    int          wa, ra1, ra2, rd;
    bit          commit, dec, any;
    logic        ehz;
    logic [31:0] e1, e2;
    wa     = int'(bus.w_rf_ctrl.addr);
    ra1    = int'(bus.rs1_addr);
    ra2    = int'(bus.rs2_addr);
    rd     = int'(bus.issue_rd_addr);
    dec    = bus.w_slot && bus.w_rf_ctrl.wen && wa != 0;
    commit = dec && bus.w_vld;
    e1     = m_read(ra1, commit, wa);
    e2     = m_read(ra2, commit, wa);
    ehz    = (bus.rs1_ren && m_busy(ra1, dec, wa)) || (bus.rs2_ren && m_busy(ra2, dec, wa)) ||
             (bus.issue_rd_en && rd != 0 && m_cnt[rd] == PMAX);
    exp_acc = bus.issue_vld && bus.issue_rd_en && !ehz;
    #1;
    obs_hz  = bus.hazard_stall;
    obs_rs1 = bus.rs1_data;
    obs_rs2 = bus.rs2_data;
    chk("hazard_stall", 32'(obs_hz), 32'(ehz));
    chk("rs1_data", obs_rs1, e1);
    chk("rs2_data", obs_rs2, e2);
    @(posedge clk);
    if (commit) m_regs[wa] = bus.w_data;
    if (dec && m_cnt[wa] > 0) m_cnt[wa]--;
    if (exp_acc && rd != 0) m_cnt[rd]++;
    any = 1'b0;
    for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) any = 1'b1;
    #1;
    obs_pa = bus.pend_any;
    chk("pend_any", 32'(obs_pa), 32'(any));
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_clear();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    bus.rs1_ren = 1'b1; bus.rs2_ren = 1'b1; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd0;
    step();
    chk("reset_x5", obs_rs1, 32'h0);
    chk("reset_stall", 32'(obs_hz), 32'h0);
    chk("reset_pend_any", 32'(obs_pa), 32'h0);

    idle(); issue(3); step();
    idle(); bus.rs1_ren = 1'b1; bus.rs1_addr = 5'd3;
    for (int c = 2; c <= 3; c++) begin
      step();
      chk("raw_stall_x3", 32'(obs_hz), 32'h1);
    end
    w_set(1'b1, 3, 32'hDEADBEEF); step();
    chk("bypass_stall", 32'(obs_hz), 32'h0);
    chk("bypass_data", obs_rs1, 32'hDEADBEEF);
    idle(); bus.rs1_ren = 1'b1; bus.rs1_addr = 5'd3; step();
    chk("array_x3", obs_rs1, 32'hDEADBEEF);

    idle(); issue(7); step();
    idle(); bus.rs1_ren = 1'b1; bus.rs1_addr = 5'd7; w_set(1'b0, 7, 32'h1234); step();
    chk("squash_stall", 32'(obs_hz), 32'h0);
    chk("squash_data", obs_rs1, 32'h0);
    chk("squash_pend_any", 32'(obs_pa), 32'h0);
    idle(); bus.rs1_ren = 1'b1; bus.rs1_addr = 5'd7; step();
    chk("squash_keep_x7", obs_rs1, 32'h0);

    for (int k = 0; k < 3; k++) begin
      idle(); issue(9); step();
      chk("fill_x9", 32'(obs_hz), 32'h0);
    end
    idle(); issue(9); step();
    chk("full_stall", 32'(obs_hz), 32'h1);
    w_set(1'b1, 9, 32'h99); step();
    chk("full_retire_stall", 32'(obs_hz), 32'h1);
    idle(); issue(9); step();
    chk("full_accept", 32'(obs_hz), 32'h0);
    for (int k = 0; k < 3; k++) begin
      idle(); w_set(1'b1, 9, 32'h900 + 32'(k)); step();
    end

    idle(); w_set(1'b1, 0, 32'hFFFFFFFF); issue(0);
    bus.rs1_ren = 1'b1; bus.rs2_ren = 1'b1; bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
    step();
    chk("x0_rs1", obs_rs1, 32'h0);
    chk("x0_rs2", obs_rs2, 32'h0);
    chk("x0_stall", 32'(obs_hz), 32'h0);
    chk("x0_pend_any", 32'(obs_pa), 32'h0);

    idle(); issue(4); step();
    issue(4); w_set(1'b1, 4, 32'h44); step();
    chk("inc_dec_pend_any", 32'(obs_pa), 32'h1);
    idle(); bus.rs1_ren = 1'b1; bus.rs1_addr = 5'd4; step();
    chk("inc_dec_still_busy", 32'(obs_hz), 32'h1);

    #2 rst_n = 1'b0;
    idle(); bus.rs1_ren = 1'b1; bus.rs1_addr = 5'd3;
    #1;
    chk("async_pend_any", 32'(bus.pend_any), 32'h0);
    chk("async_stall", 32'(bus.hazard_stall), 32'h0);
    chk("async_array", bus.rs1_data, 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int a;
      idle();
      bus.rs1_ren  = 1'($urandom_range(0, 1));
      bus.rs2_ren  = 1'($urandom_range(0, 1));
      bus.rs1_addr = 5'($urandom_range(0, 9));
      bus.rs2_addr = 5'($urandom_range(0, 31));
      if (q.size() > 0 && $urandom_range(0, 9) < 5) begin
        a = q.pop_front();
        w_set(1'($urandom_range(0, 4) != 0), a, $urandom);
      end else begin
        bus.w_slot         = 1'($urandom_range(0, 1));
        bus.w_vld          = 1'($urandom_range(0, 1));
        bus.w_rf_ctrl.wen  = bus.w_slot ? 1'b0 : 1'($urandom_range(0, 1));
        bus.w_rf_ctrl.addr = 5'($urandom_range(0, 31));
        bus.w_data         = $urandom;
      end
      if (q.size() < 8) begin
        bus.issue_vld     = 1'($urandom_range(0, 1));
        bus.issue_rd_en   = 1'($urandom_range(0, 3) != 0);
        bus.issue_rd_addr = 5'($urandom_range(0, 9));
      end
      a = int'(bus.issue_rd_addr);
      step();
      if (exp_acc) q.push_back(a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
